// File: rtl/micro_code_table1_pkg.sv
// Shared encodings for the 6502 micro-code table: micro-op indices, bus and
// sequencing codes, addressing-mode enum and the micro-word builders.
package micro_code_table1_pkg;

   localparam logic [4:0] OP_FETCH_AL    = 5'd0;
   localparam logic [4:0] OP_FETCH_AH    = 5'd1;
   localparam logic [4:0] OP_ALU_REG     = 5'd2;
   localparam logic [4:0] OP_READ_T      = 5'd3;
   localparam logic [4:0] OP_RMW_MOD     = 5'd4;
   localparam logic [4:0] OP_RMW_WR      = 5'd5;
   localparam logic [4:0] OP_STORE       = 5'd6;
   localparam logic [4:0] OP_INDEX_AL    = 5'd7;
   localparam logic [4:0] OP_FETCH_AH_IX = 5'd8;
   localparam logic [4:0] OP_FIX_AH      = 5'd9;
   localparam logic [4:0] OP_PTR_LO      = 5'd10;
   localparam logic [4:0] OP_PTR_HI      = 5'd11;
   localparam logic [4:0] OP_PTR_HI_Y    = 5'd12;
   localparam logic [4:0] OP_ALU_IMM     = 5'd13;
   localparam logic [4:0] OP_PUSH_A      = 5'd14;
   localparam logic [4:0] OP_PUSH_P      = 5'd15;
   localparam logic [4:0] OP_SP_INC      = 5'd16;
   localparam logic [4:0] OP_BRANCH      = 5'd17;
   localparam logic [4:0] OP_TXS         = 5'd18;
   localparam logic [4:0] OP_LOAD_PC     = 5'd19;
   localparam logic [4:0] OP_PUSH_PC     = 5'd20;
   localparam logic [4:0] OP_PUSH_P_BRK  = 5'd21;
   localparam logic [4:0] OP_PULL_P      = 5'd22;

   localparam logic [1:0] BUS_PC    = 2'b00;
   localparam logic [1:0] BUS_AX    = 2'b01;
   localparam logic [1:0] BUS_STACK = 2'b10;
   localparam logic [1:0] BUS_VEC   = 2'b11;

   localparam logic [1:0] NX_STEP   = 2'b00;
   localparam logic [1:0] NX_END    = 2'b01;
   localparam logic [1:0] NX_BRANCH = 2'b10;
   localparam logic [1:0] NX_PAGE   = 2'b11;

   localparam logic [8:0] W_UNDEF = 9'h0A3;

   typedef enum logic [4:0] {
      MODE_UNDEF, MODE_IMM, MODE_IMPL, MODE_ZP, MODE_ZPX, MODE_ABS, MODE_ABSX,
      MODE_INDX, MODE_INDY, MODE_BRANCH, MODE_PHA, MODE_PHP, MODE_PLA,
      MODE_PLP, MODE_JMP, MODE_JSR, MODE_RTS, MODE_RTI, MODE_BRK, MODE_TXS
   } mode_t;

   typedef enum logic [1:0] {ACC_READ, ACC_WRITE, ACC_RMW} acc_t;

   function automatic logic [8:0] uword(input logic [1:0] nx, input logic [1:0] bus,
                                        input logic [4:0] op);
      return {nx, bus, op};
   endfunction

   // Number of address-forming cycles before the data access starts.
   function automatic logic [2:0] prefix_len(input mode_t mode);
      logic [2:0] len;
      case (mode)
         MODE_ZP:   len = 3'd1;
         MODE_ZPX:  len = 3'd2;
         MODE_ABS:  len = 3'd2;
         MODE_ABSX: len = 3'd3;
         MODE_INDX: len = 3'd4;
         MODE_INDY: len = 3'd4;
         default:   len = 3'd0;
      endcase
      return len;
   endfunction

   function automatic logic [8:0] access_word(input acc_t kind, input logic [2:0] step);
      logic [8:0] w;
      case (kind)
         ACC_READ:  w = (step == 3'd0) ? uword(NX_END, BUS_AX, OP_ALU_REG) : W_UNDEF;
         ACC_WRITE: w = (step == 3'd0) ? uword(NX_END, BUS_AX, OP_STORE) : W_UNDEF;
         ACC_RMW: begin
            case (step)
               3'd0:    w = uword(NX_STEP, BUS_AX, OP_READ_T);
               3'd1:    w = uword(NX_STEP, BUS_AX, OP_RMW_MOD);
               3'd2:    w = uword(NX_END,  BUS_AX, OP_RMW_WR);
               default: w = W_UNDEF;
            endcase
         end
         default:   w = W_UNDEF;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/micro_code_table1.sv
// 6502 micro-code ROM: decodes the addressing mode from the opcode grid and
// registers the micro-word for the current micro-cycle.
module micro_code_table1
   import micro_code_table1_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic [7:0] IR,
   input  logic [2:0] State,
   output logic [8:0] M
);

   logic [1:0] cc;
   logic [2:0] bbb;
   logic [2:0] aaa;
   mode_t      mode;
   acc_t       kind;
   logic [2:0] acc_step;
   logic [8:0] acc_m;
   logic [8:0] next_m;

   assign cc  = IR[1:0];
   assign bbb = IR[4:2];
   assign aaa = IR[7:5];

   // Addressing mode and access kind from the aaa/bbb/cc opcode grid.
   always_comb begin
      mode = MODE_UNDEF;
      kind = ACC_READ;
      case (cc)
         2'b01: begin
            kind = (aaa == 3'd4) ? ACC_WRITE : ACC_READ;
            case (bbb)
               3'd0:    mode = MODE_INDX;
               3'd1:    mode = MODE_ZP;
               3'd2:    mode = (aaa == 3'd4) ? MODE_UNDEF : MODE_IMM;
               3'd3:    mode = MODE_ABS;
               3'd4:    mode = MODE_INDY;
               3'd5:    mode = MODE_ZPX;
               3'd6:    mode = MODE_ABSX;
               3'd7:    mode = MODE_ABSX;
               default: mode = MODE_UNDEF;
            endcase
         end
         2'b10: begin
            kind = (aaa == 3'd4) ? ACC_WRITE : ((aaa == 3'd5) ? ACC_READ : ACC_RMW);
            case (bbb)
               3'd0:    mode = (aaa == 3'd5) ? MODE_IMM : MODE_UNDEF;
               3'd1:    mode = MODE_ZP;
               3'd2:    mode = MODE_IMPL;
               3'd3:    mode = MODE_ABS;
               3'd5:    mode = MODE_ZPX;
               3'd6:    mode = (IR == 8'h9A) ? MODE_TXS :
                               ((IR == 8'hBA) ? MODE_IMPL : MODE_UNDEF);
               3'd7:    mode = (aaa == 3'd4) ? MODE_UNDEF : MODE_ABSX;
               default: mode = MODE_UNDEF;
            endcase
         end
         2'b00: begin
            kind = (aaa == 3'd4) ? ACC_WRITE : ACC_READ;
            case (bbb)
               3'd0: begin
                  case (aaa)
                     3'd0:    mode = MODE_BRK;
                     3'd1:    mode = MODE_JSR;
                     3'd2:    mode = MODE_RTI;
                     3'd3:    mode = MODE_RTS;
                     3'd5:    mode = MODE_IMM;
                     3'd6:    mode = MODE_IMM;
                     3'd7:    mode = MODE_IMM;
                     default: mode = MODE_UNDEF;
                  endcase
               end
               3'd1:    mode = (aaa == 3'd1 || aaa >= 3'd4) ? MODE_ZP : MODE_UNDEF;
               3'd2: begin
                  case (aaa)
                     3'd0:    mode = MODE_PHP;
                     3'd1:    mode = MODE_PLP;
                     3'd2:    mode = MODE_PHA;
                     3'd3:    mode = MODE_PLA;
                     default: mode = MODE_IMPL;
                  endcase
               end
               3'd3: begin
                  case (aaa)
                     3'd0:    mode = MODE_UNDEF;
                     3'd2:    mode = MODE_JMP;
                     3'd3:    mode = MODE_UNDEF;
                     default: mode = MODE_ABS;
                  endcase
               end
               3'd4:    mode = MODE_BRANCH;
               3'd5:    mode = (aaa == 3'd4 || aaa == 3'd5) ? MODE_ZPX : MODE_UNDEF;
               3'd6:    mode = MODE_IMPL;
               3'd7:    mode = (aaa == 3'd5) ? MODE_ABSX : MODE_UNDEF;
               default: mode = MODE_UNDEF;
            endcase
         end
         default: begin
            mode = MODE_UNDEF;
            kind = ACC_READ;
         end
      endcase
   end

   // Micro-word table: address-forming prefix per mode, then the shared access tail.
   always_comb begin
      acc_step = State - prefix_len(mode);
      acc_m    = access_word(kind, acc_step);
      next_m   = W_UNDEF;
      case (mode)
         MODE_IMM:  next_m = (State == 3'd0) ? uword(NX_END, BUS_PC, OP_ALU_IMM) : W_UNDEF;
         MODE_IMPL: next_m = (State == 3'd0) ? uword(NX_END, BUS_PC, OP_ALU_REG) : W_UNDEF;
         MODE_TXS:  next_m = (State == 3'd0) ? uword(NX_END, BUS_PC, OP_TXS) : W_UNDEF;
         MODE_ZP:   next_m = (State == 3'd0) ? uword(NX_STEP, BUS_PC, OP_FETCH_AL) : acc_m;
         MODE_ZPX: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_STEP, BUS_AX, OP_INDEX_AL);
               default: next_m = acc_m;
            endcase
         end
         MODE_ABS: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AH);
               default: next_m = acc_m;
            endcase
         end
         MODE_ABSX: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_PAGE, BUS_PC, OP_FETCH_AH_IX);
               3'd2:    next_m = uword(NX_STEP, BUS_AX, OP_FIX_AH);
               default: next_m = acc_m;
            endcase
         end
         MODE_INDX: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_STEP, BUS_AX, OP_INDEX_AL);
               3'd2:    next_m = uword(NX_STEP, BUS_AX, OP_PTR_LO);
               3'd3:    next_m = uword(NX_STEP, BUS_AX, OP_PTR_HI);
               default: next_m = acc_m;
            endcase
         end
         MODE_INDY: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_STEP, BUS_AX, OP_PTR_LO);
               3'd2:    next_m = uword(NX_PAGE, BUS_AX, OP_PTR_HI_Y);
               3'd3:    next_m = uword(NX_STEP, BUS_AX, OP_FIX_AH);
               default: next_m = acc_m;
            endcase
         end
         MODE_BRANCH: begin
            case (State)
               3'd0:    next_m = uword(NX_BRANCH, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_PAGE, BUS_PC, OP_BRANCH);
               3'd2:    next_m = uword(NX_END, BUS_PC, OP_FIX_AH);
               default: next_m = W_UNDEF;
            endcase
         end
         MODE_PHA, MODE_PHP: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_READ_T);
               3'd1:    next_m = uword(NX_END, BUS_STACK,
                                       (mode == MODE_PHA) ? OP_PUSH_A : OP_PUSH_P);
               default: next_m = W_UNDEF;
            endcase
         end
         MODE_PLA, MODE_PLP: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_READ_T);
               3'd1:    next_m = uword(NX_STEP, BUS_STACK, OP_SP_INC);
               3'd2:    next_m = uword(NX_END, BUS_STACK,
                                       (mode == MODE_PLA) ? OP_ALU_REG : OP_PULL_P);
               default: next_m = W_UNDEF;
            endcase
         end
         MODE_JMP: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_END, BUS_PC, OP_LOAD_PC);
               default: next_m = W_UNDEF;
            endcase
         end
         MODE_JSR: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_STEP, BUS_STACK, OP_READ_T);
               3'd2:    next_m = uword(NX_STEP, BUS_STACK, OP_PUSH_PC);
               3'd3:    next_m = uword(NX_STEP, BUS_STACK, OP_PUSH_PC);
               3'd4:    next_m = uword(NX_END, BUS_PC, OP_LOAD_PC);
               default: next_m = W_UNDEF;
            endcase
         end
         MODE_RTS: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_READ_T);
               3'd1:    next_m = uword(NX_STEP, BUS_STACK, OP_SP_INC);
               3'd2:    next_m = uword(NX_STEP, BUS_STACK, OP_SP_INC);
               3'd3:    next_m = uword(NX_STEP, BUS_STACK, OP_LOAD_PC);
               3'd4:    next_m = uword(NX_END, BUS_PC, OP_READ_T);
               default: next_m = W_UNDEF;
            endcase
         end
         MODE_RTI: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_READ_T);
               3'd1:    next_m = uword(NX_STEP, BUS_STACK, OP_SP_INC);
               3'd2:    next_m = uword(NX_STEP, BUS_STACK, OP_PULL_P);
               3'd3:    next_m = uword(NX_STEP, BUS_STACK, OP_SP_INC);
               3'd4:    next_m = uword(NX_END, BUS_STACK, OP_LOAD_PC);
               default: next_m = W_UNDEF;
            endcase
         end
         MODE_BRK: begin
            case (State)
               3'd0:    next_m = uword(NX_STEP, BUS_PC, OP_FETCH_AL);
               3'd1:    next_m = uword(NX_STEP, BUS_STACK, OP_PUSH_PC);
               3'd2:    next_m = uword(NX_STEP, BUS_STACK, OP_PUSH_PC);
               3'd3:    next_m = uword(NX_STEP, BUS_STACK, OP_PUSH_P_BRK);
               3'd4:    next_m = uword(NX_STEP, BUS_VEC, OP_READ_T);
               3'd5:    next_m = uword(NX_END, BUS_VEC, OP_LOAD_PC);
               default: next_m = W_UNDEF;
            endcase
         end
         default: next_m = W_UNDEF;
      endcase
   end

   // Output micro-word register with clock enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         M <= 9'h000;
      end else if (ce) begin
         M <= next_m;
      end
   end

endmodule

// File: tb/tb_micro_code_table1.sv
// Directed-vector bench for micro_code_table1: table lookups plus reset and
// clock-enable sequences.
module tb_micro_code_table1;

   logic       clk;
   logic       reset;
   logic       ce;
   logic [7:0] IR;
   logic [2:0] State;
   logic [8:0] M;

   int errors = 0;
   int checks = 0;

   micro_code_table1 dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .IR    (IR),
      .State (State),
      .M     (M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ir;
      logic [2:0] st;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: M=%03h expected %03h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] ir, input logic [2:0] st, input logic [8:0] exp);
      vec_t v;
      v.ir = ir; v.st = st; v.exp = exp;
      vecs.push_back(v);
   endtask

   initial begin
      add(8'hA9, 3'd0, 9'h08D);  // LDA #
      add(8'hBD, 3'd0, 9'h000);  // LDA abs,X
      add(8'hBD, 3'd1, 9'h188);
      add(8'hBD, 3'd2, 9'h029);
      add(8'hBD, 3'd3, 9'h0A2);
      add(8'hBD, 3'd4, 9'h0A3);
      add(8'h48, 3'd0, 9'h003);  // PHA
      add(8'h48, 3'd1, 9'h0CE);
      add(8'h02, 3'd0, 9'h0A3);  // undefined
      add(8'hFF, 3'd0, 9'h0A3);
      add(8'hD0, 3'd0, 9'h100);  // BNE
      add(8'hD0, 3'd1, 9'h191);
      add(8'hD0, 3'd2, 9'h089);
      add(8'hEA, 3'd0, 9'h082);  // NOP
      add(8'h0A, 3'd0, 9'h082);  // ASL A
      add(8'h9A, 3'd0, 9'h092);  // TXS
      add(8'h9A, 3'd1, 9'h0A3);
      add(8'hA2, 3'd0, 9'h08D);  // LDX #
      add(8'h8D, 3'd2, 9'h0A6);  // STA abs
      add(8'hEE, 3'd2, 9'h023);  // INC abs
      add(8'hEE, 3'd3, 9'h024);
      add(8'hEE, 3'd4, 9'h0A5);
      add(8'hA1, 3'd1, 9'h027);  // LDA (zp,X)
      add(8'hA1, 3'd2, 9'h02A);
      add(8'hA1, 3'd3, 9'h02B);
      add(8'hA1, 3'd4, 9'h0A2);
      add(8'hB1, 3'd2, 9'h1AC);  // LDA (zp),Y
      add(8'h96, 3'd1, 9'h027);  // STX zp,Y
      add(8'h96, 3'd2, 9'h0A6);
      add(8'h00, 3'd4, 9'h063);  // BRK
      add(8'h00, 3'd5, 9'h0F3);
      add(8'h20, 3'd1, 9'h043);  // JSR
      add(8'h20, 3'd4, 9'h093);
      add(8'h60, 3'd4, 9'h083);  // RTS
      add(8'h40, 3'd4, 9'h0D3);  // RTI
      add(8'h68, 3'd2, 9'h0C2);  // PLA
      add(8'h28, 3'd2, 9'h0D6);  // PLP
      add(8'h08, 3'd1, 9'h0CF);  // PHP
      add(8'h4C, 3'd1, 9'h093);  // JMP abs

      reset = 1'b1; ce = 1'b0; IR = 8'hA9; State = 3'd0;
      repeat (2) @(posedge clk);
      #1 check("reset_state", M, 9'h000);
      reset = 1'b0;
      @(posedge clk); #1;
      check("hold_after_release", M, 9'h000);
      ce = 1'b1;
      @(posedge clk); #1;
      check("first_ce_load", M, 9'h08D);

      for (int i = 0; i < vecs.size(); i++) begin
         IR = vecs[i].ir; State = vecs[i].st;
         @(posedge clk); #1;
         checks++;
         if (M !== vecs[i].exp) begin
            errors++;
            $display("FAIL vec%0d IR=%02h State=%0d: M=%03h expected %03h",
                     i, vecs[i].ir, vecs[i].st, M, vecs[i].exp);
         end
      end

      // Clock enable low: output holds while inputs change.
      IR = 8'hA9; State = 3'd0; ce = 1'b1;
      @(posedge clk); #1;
      check("ce_preload", M, 9'h08D);
      ce = 1'b0;
      for (int k = 0; k < 3; k++) begin
         IR = 8'hD0 + 8'(k); State = 3'(k + 1);
         @(posedge clk); #1;
         check("ce_hold", M, 9'h08D);
      end

      // Mid-run reset with ce high clears immediately and dominates ce.
      ce = 1'b1; IR = 8'hBD; State = 3'd1;
      @(posedge clk); #1;
      check("pre_reset_load", M, 9'h188);
      #2 reset = 1'b1;
      #1 check("reset_async", M, 9'h000);
      @(posedge clk); #1;
      check("reset_dominates_ce", M, 9'h000);
      reset = 1'b0; ce = 1'b0;
      @(posedge clk); #1;
      check("post_reset_hold", M, 9'h000);
      ce = 1'b1; IR = 8'hD0; State = 3'd1;
      @(posedge clk); #1;
      check("post_reset_first_ce", M, 9'h191);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
